// File: rtl/game_pkg.sv
// Shared match definitions: FSM states, winner codes and HUD-facing defaults.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam int DEF_MAX_HEALTH    = 5;
    localparam int DEF_MAX_LIVES     = 3;
    localparam int DEF_HIT_DAMAGE    = 1;
    localparam int DEF_INVULN_FRAMES = 60;

    // The player whose opponent runs out of lives wins.
    function automatic logic [1:0] resolve_winner(input logic p1_out,
                                                  input logic p2_out);
        logic [1:0] w;
        w = WIN_NONE;
        unique case (1'b1)
            (p1_out & p2_out):  w = WIN_DRAW;
            (p2_out & ~p1_out): w = WIN_P1;
            (p1_out & ~p2_out): w = WIN_P2;
            default:            w = WIN_NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/player_life_tracker.sv
// Health, lives and post-respawn immunity for one player.
module player_life_tracker
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int HIT_DAMAGE    = DEF_HIT_DAMAGE,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int HW = $clog2(MAX_HEALTH + 1),
    parameter int LW = $clog2(MAX_LIVES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          hit_i,
    input  logic          fell_i,
    input  logic          tick_i,
    input  logic          enable_i,
    input  logic          reload_i,
    output logic [HW-1:0] health_o,
    output logic [LW-1:0] lives_o,
    output logic          respawn_o,
    output logic          out_of_lives_o
);

    localparam int IW = $clog2(INVULN_FRAMES + 1);

    logic [HW-1:0] health_q, health_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [IW-1:0] invuln_q, invuln_d;
    logic          respawn_q, respawn_d;
    logic          hit_ok;
    logic          fatal;

    assign hit_ok = enable_i & hit_i & ~fell_i & (invuln_q == '0);
    assign fatal  = enable_i & (lives_q != '0) &
                    (fell_i | (hit_ok & (health_q <= HW'(HIT_DAMAGE))));

    // Flags the edge on which the last life goes, so the top can
    // register the winner on that same edge.
    assign out_of_lives_o = fatal & (lives_q == LW'(1));

    always_comb begin
        health_d  = health_q;
        lives_d   = lives_q;
        invuln_d  = invuln_q;
        respawn_d = 1'b0;
        if (reload_i) begin
            health_d = HW'(MAX_HEALTH);
            lives_d  = LW'(MAX_LIVES);
            invuln_d = '0;
        end else if (fatal) begin
            if (lives_q > LW'(1)) begin
                lives_d   = lives_q - LW'(1);
                health_d  = HW'(MAX_HEALTH);
                respawn_d = 1'b1;
                invuln_d  = IW'(INVULN_FRAMES);
            end else begin
                lives_d  = '0;
                health_d = '0;
            end
        end else begin
            if (hit_ok) begin
                health_d = health_q - HW'(HIT_DAMAGE);
            end
            if (enable_i && tick_i && invuln_q != '0) begin
                invuln_d = invuln_q - IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            health_q  <= HW'(MAX_HEALTH);
            lives_q   <= LW'(MAX_LIVES);
            invuln_q  <= '0;
            respawn_q <= 1'b0;
        end else begin
            health_q  <= health_d;
            lives_q   <= lives_d;
            invuln_q  <= invuln_d;
            respawn_q <= respawn_d;
        end
    end

    assign health_o  = health_q;
    assign lives_o   = lives_q;
    assign respawn_o = respawn_q;

endmodule

// File: rtl/game_state_tracker.sv
// Match bookkeeping: frame tick sync, top FSM, winner resolution,
// and two per-player life trackers feeding the colour mapper.
module game_state_tracker
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int HIT_DAMAGE    = DEF_HIT_DAMAGE,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       p1_fell,
    input  logic       p2_fell,
    output logic [9:0] Player1Health,
    output logic [9:0] Player2Health,
    output logic [9:0] Player1Lives,
    output logic [9:0] Player2Lives,
    output logic [1:0] winner,
    output logic       p1_respawn,
    output logic       p2_respawn,
    output logic       game_active
);

    localparam int HW = $clog2(MAX_HEALTH + 1);
    localparam int LW = $clog2(MAX_LIVES + 1);

    logic [2:0]    fsync_q;
    logic          tick;
    state_e        state_q, state_d;
    logic [1:0]    winner_q, winner_d;
    logic          reload;
    logic          enable;
    logic          p1_out, p2_out;
    logic [HW-1:0] p1_health, p2_health;
    logic [LW-1:0] p1_lives, p2_lives;

    // Bits 0..1 synchronise frame_clk, bit 2 remembers the previous level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync_q <= '0;
        end else begin
            fsync_q <= {fsync_q[1:0], frame_clk};
        end
    end

    assign tick   = fsync_q[1] & ~fsync_q[2];
    assign enable = (state_q == PLAY);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        reload   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    reload  = 1'b1;
                end
            end
            PLAY: begin
                if (p1_out || p2_out) begin
                    state_d  = OVER;
                    winner_d = resolve_winner(p1_out, p2_out);
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    reload   = 1'b1;
                    winner_d = WIN_NONE;
                end
            end
            default: begin
                state_d  = IDLE;
                winner_d = WIN_NONE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    player_life_tracker #(
        .MAX_HEALTH   (MAX_HEALTH),
        .MAX_LIVES    (MAX_LIVES),
        .HIT_DAMAGE   (HIT_DAMAGE),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_p1 (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .hit_i         (p1_hit),
        .fell_i        (p1_fell),
        .tick_i        (tick),
        .enable_i      (enable),
        .reload_i      (reload),
        .health_o      (p1_health),
        .lives_o       (p1_lives),
        .respawn_o     (p1_respawn),
        .out_of_lives_o(p1_out)
    );

    player_life_tracker #(
        .MAX_HEALTH   (MAX_HEALTH),
        .MAX_LIVES    (MAX_LIVES),
        .HIT_DAMAGE   (HIT_DAMAGE),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_p2 (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .hit_i         (p2_hit),
        .fell_i        (p2_fell),
        .tick_i        (tick),
        .enable_i      (enable),
        .reload_i      (reload),
        .health_o      (p2_health),
        .lives_o       (p2_lives),
        .respawn_o     (p2_respawn),
        .out_of_lives_o(p2_out)
    );

    assign Player1Health = 10'(p1_health);
    assign Player2Health = 10'(p2_health);
    assign Player1Lives  = 10'(p1_lives);
    assign Player2Lives  = 10'(p2_lives);
    assign winner        = winner_q;
    assign game_active   = enable;

endmodule

// File: tb/tb_game_state_tracker.sv
// Directed scoreboard bench for game_state_tracker.
module tb_game_state_tracker;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start = 1'b0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic       p1_fell = 1'b0;
    logic       p2_fell = 1'b0;
    logic [9:0] Player1Health, Player2Health;
    logic [9:0] Player1Lives, Player2Lives;
    logic [1:0] winner;
    logic       p1_respawn, p2_respawn, game_active;

    game_state_tracker dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .start        (start),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .p1_fell      (p1_fell),
        .p2_fell      (p2_fell),
        .Player1Health(Player1Health),
        .Player2Health(Player2Health),
        .Player1Lives (Player1Lives),
        .Player2Lives (Player2Lives),
        .winner       (winner),
        .p1_respawn   (p1_respawn),
        .p2_respawn   (p2_respawn),
        .game_active  (game_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string nm;
        int    when;
        int    h1, h2, l1, l2, w, a, r1, r2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        while (q.size() != 0 && q[0].when <= cyc) begin
            exp_t e;
            int   gh1, gh2, gl1, gl2, gw, ga, gr1, gr2;
            e   = q.pop_front();
            gh1 = int'(Player1Health);
            gh2 = int'(Player2Health);
            gl1 = int'(Player1Lives);
            gl2 = int'(Player2Lives);
            gw  = int'(winner);
            ga  = int'(game_active);
            gr1 = int'(p1_respawn);
            gr2 = int'(p2_respawn);
            n_vec++;
            if (e.when != cyc || gh1 != e.h1 || gh2 != e.h2 ||
                gl1 != e.l1 || gl2 != e.l2 || gw != e.w ||
                ga != e.a || gr1 != e.r1 || gr2 != e.r2) begin
                n_bad++;
                $display("FAIL %s @%0d: got h=%0d/%0d l=%0d/%0d w=%0d a=%0d r=%0d%0d, want h=%0d/%0d l=%0d/%0d w=%0d a=%0d r=%0d%0d @%0d",
                         e.nm, cyc, gh1, gh2, gl1, gl2, gw, ga, gr1, gr2,
                         e.h1, e.h2, e.l1, e.l2, e.w, e.a, e.r1, e.r2,
                         e.when);
            end
        end
    end

    task automatic expect_now(input string nm,
                              input int h1, input int h2,
                              input int l1, input int l2,
                              input int w, input int a,
                              input int r1, input int r2);
        exp_t e;
        e.nm = nm; e.when = cyc;
        e.h1 = h1; e.h2 = h2; e.l1 = l1; e.l2 = l2;
        e.w = w; e.a = a; e.r1 = r1; e.r2 = r2;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic h1, input logic h2,
                         input logic f1, input logic f2);
        start = s; p1_hit = h1; p2_hit = h2; p1_fell = f1; p2_fell = f2;
        @(posedge Clk);
        #1;
        start = 0; p1_hit = 0; p2_hit = 0; p1_fell = 0; p2_fell = 0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            idle(4);
            frame_clk = 1'b0;
            idle(4);
        end
    endtask

    initial begin
        idle(3);
        expect_now("reset", 5, 5, 3, 3, 0, 0, 0, 0);
        Reset_n = 1'b1;
        idle(2);
        pulse(0, 1, 0, 1, 0);
        expect_now("idle_ignore", 5, 5, 3, 3, 0, 0, 0, 0);
        idle(2);
        pulse(1, 0, 0, 0, 0);
        expect_now("start", 5, 5, 3, 3, 0, 1, 0, 0);
        idle(3);
        pulse(1, 0, 0, 0, 0);
        expect_now("play_start_ign", 5, 5, 3, 3, 0, 1, 0, 0);
        idle(3);

        for (int i = 0; i < 4; i++) begin
            pulse(0, 1, 0, 0, 0);
            expect_now("p1_hit_dmg", 4 - i, 5, 3, 3, 0, 1, 0, 0);
            idle(9);
        end
        pulse(0, 1, 0, 0, 0);
        expect_now("p1_respawn", 5, 5, 2, 3, 0, 1, 1, 0);
        idle(1);
        expect_now("p1_resp_end", 5, 5, 2, 3, 0, 1, 0, 0);
        idle(2);
        pulse(0, 1, 0, 0, 0);
        expect_now("invuln_hit", 5, 5, 2, 3, 0, 1, 0, 0);
        frames(59);
        idle(2);
        pulse(0, 1, 0, 0, 0);
        expect_now("invuln_59", 5, 5, 2, 3, 0, 1, 0, 0);
        frames(1);
        idle(2);
        pulse(0, 1, 0, 0, 0);
        expect_now("invuln_done", 4, 5, 2, 3, 0, 1, 0, 0);
        idle(3);
        pulse(0, 0, 0, 1, 0);
        expect_now("p1_fell", 5, 5, 1, 3, 0, 1, 1, 0);
        idle(2);
        pulse(0, 1, 0, 0, 0);
        expect_now("p1_inv_hit", 5, 5, 1, 3, 0, 1, 0, 0);
        idle(2);

        pulse(0, 0, 0, 0, 1);
        expect_now("p2_fell1", 5, 5, 1, 2, 0, 1, 0, 1);
        idle(3);
        pulse(0, 0, 0, 0, 1);
        expect_now("p2_fell2", 5, 5, 1, 1, 0, 1, 0, 1);
        idle(3);
        pulse(0, 0, 0, 0, 1);
        expect_now("p2_out", 5, 0, 1, 0, 1, 0, 0, 0);
        idle(2);
        pulse(0, 1, 1, 1, 1);
        expect_now("over_ignore", 5, 0, 1, 0, 1, 0, 0, 0);
        idle(2);
        pulse(1, 0, 0, 0, 0);
        expect_now("restart", 5, 5, 3, 3, 0, 1, 0, 0);
        idle(2);

        pulse(0, 1, 0, 1, 0);
        expect_now("hit_fell_same", 5, 5, 2, 3, 0, 1, 1, 0);
        idle(2);
        pulse(0, 0, 0, 1, 0);
        expect_now("fell_in_invuln", 5, 5, 1, 3, 0, 1, 1, 0);
        idle(2);
        pulse(0, 0, 0, 0, 1);
        idle(2);
        pulse(0, 0, 0, 0, 1);
        expect_now("p2_one_life", 5, 5, 1, 1, 0, 1, 0, 1);
        idle(2);
        pulse(0, 0, 0, 1, 1);
        expect_now("draw", 0, 0, 0, 0, 3, 0, 0, 0);
        idle(2);

        pulse(1, 0, 0, 0, 0);
        expect_now("restart2", 5, 5, 3, 3, 0, 1, 0, 0);
        idle(2);
        pulse(0, 0, 0, 1, 0);
        #1 Reset_n = 1'b0;
        expect_now("async_rst", 5, 5, 3, 3, 0, 0, 0, 0);
        idle(2);
        Reset_n = 1'b1;
        idle(2);
        pulse(0, 0, 0, 1, 1);
        expect_now("post_rst_idle", 5, 5, 3, 3, 0, 0, 0, 0);
        idle(2);
        pulse(1, 0, 0, 0, 0);
        expect_now("resume", 5, 5, 3, 3, 0, 1, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations pending, want 0",
                     q.size());
            n_bad += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/game_state_tracker.md
Name: game_state_tracker

Overview:
- Match-level bookkeeping stage directly upstream of the colour mapper.
- Consumes per-player hit and fall events from the collision/physics logic.
- Maintains health, lives, invulnerability windows and the winner code.
- Drives the colour mapper's Player1Health, Player2Health, Player1Lives, Player2Lives and winner inputs, and emits respawn pulses to the player motion blocks.

Parameters:
- MAX_HEALTH, 5: health reload value. Health bar width is health*20 px.
- MAX_LIVES, 3: lives reload value.
- HIT_DAMAGE, 1: health removed per accepted hit.
- INVULN_FRAMES, 60: frames of hit immunity after a respawn.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-rate frame signal, asynchronous to logic; rising edge = one frame.
- start  in  1  one-Clk pulse from keyboard decode; begins or restarts a match.
- p1_hit, p2_hit  in  1  one-Clk pulse: player N struck by the opponent's bullet.
- p1_fell, p2_fell  in  1  one-Clk pulse: player N left the map (fatal).
- Player1Health, Player2Health  out  10  current health, 0..MAX_HEALTH.
- Player1Lives, Player2Lives  out  10  current lives, 0..MAX_LIVES.
- winner  out  2  0 = none, 1 = P1 wins, 2 = P2 wins, 3 = draw.
- p1_respawn, p2_respawn  out  1  one-Clk pulse: reposition player N.
- game_active  out  1  high only in PLAY.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - Health = MAX_HEALTH, lives = MAX_LIVES.
  - winner = 0, respawn pulses = 0, game_active = 0.
  - Invulnerability counters = 0.
  - Frame synchroniser flops = 0.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser plus one edge register.
  - tick = one Clk cycle on each rising edge.
  - Latency from the frame_clk edge is 3 Clk cycles.
- Top FSM (three states):
  - IDLE: start -> PLAY with all counters reloaded. Hit and fall inputs are ignored.
  - PLAY: start is ignored. On the same edge that any player's lives reach 0 -> OVER, with winner registered on that edge.
  - OVER: hit and fall inputs are ignored; outputs hold. start -> PLAY with full reload and winner = 0.
- Per-player tracker (identical for P1/P2; evaluated only in PLAY):
  - Accepted hit: hit = 1, fell = 0, invuln = 0.
  - Fatal event: fell = 1 (accepted even while invulnerable), or an accepted hit with health <= HIT_DAMAGE.
  - Non-fatal accepted hit: health -= HIT_DAMAGE at the next edge (1-cycle latency).
  - Fatal event with lives > 1, all at the next edge:
    - lives -= 1 and health = MAX_HEALTH.
    - respawn pulses high for exactly 1 cycle.
    - invuln loaded with INVULN_FRAMES.
  - Fatal event with lives == 1: lives = 0 and health = 0; no respawn pulse.
  - hit and fell in the same cycle: fell dominates, so one life is lost, not two.
  - Hit while invuln != 0: dropped, no state change.
  - invuln decrements by 1 per tick, saturating at 0. Immunity therefore lasts INVULN_FRAMES ticks; the first hit accepted is in the cycle after the count reaches 0.
- Winner resolution, on the edge lives reach 0:
  - Only P2 reaches 0 -> winner = 1.
  - Only P1 reaches 0 -> winner = 2.
  - Both reach 0 on the same edge -> winner = 3. The mapper renders a blank banner for this code.
- Width rules:
  - Counters are internally ceil(log2(MAX+1)) bits, zero-extended to 10-bit outputs.
  - Health is never below 0 and lives never wrap.
  - Health reads 0 only after the final death.
- Reset asserted mid-match: immediate return to IDLE with reset values. Any pending respawn pulse is cancelled.

Decomposition:
- game_pkg:
  - state enum {IDLE, PLAY, OVER}.
  - winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW.
  - MAX_HEALTH, MAX_LIVES, INVULN_FRAMES defaults, shared with the colour mapper's HUD geometry.
- Sub-module player_life_tracker, instantiated twice:
  - Inputs: hit, fell, tick, enable, reload.
  - Outputs: health, lives, respawn, out_of_lives.
- Top level holds the frame synchroniser, the FSM and winner resolution.

Test Plan:
- Reset release, start pulse -> game_active = 1 one cycle later; health 5/5, lives 3/3, winner 0.
- Four p1_hit pulses 10 cycles apart -> Player1Health 4,3,2,1, each update 1 cycle after its pulse. Fifth hit -> health 5, lives 2, p1_respawn high for exactly 1 cycle.
- After that respawn, p1_hit within 60 ticks -> ignored. Hit 1 cycle after the 60th tick -> health 4. p1_fell during invuln -> lives 1, health 5.
- p2_fell three times -> Player2Lives 0, Player2Health 0, winner 1, game_active 0. Subsequent hits ignored. start -> full reload, winner 0, PLAY.
- Both players at 1 life; p1_fell and p2_fell in the same cycle -> both lives 0, winner 3. Also p1_hit and p1_fell in the same cycle at 3 lives -> lives 2 only.
- Assert Reset_n low mid-respawn cycle -> outputs return to reset values asynchronously; FSM IDLE; start required to resume.
